// File: rtl/seg7_display_scheduler.sv
// Round-robin sharing of a 4-digit BCD seven-segment display between NREQ requesters,
// with a minimum hold time per grant and a free-running scan tick prescaler.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading zero digits on latch).
module seg7_display_scheduler #(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned SCAN_DIV    = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   data,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic [1:0]           owner,
  output logic [15:0]          bcd_out,
  output logic                 scan_tick
);

  localparam int unsigned BCD_W = 16;
  localparam logic [BCD_W-1:0] BLANK = 16'hFFFF;

  typedef enum logic [0:0] {IDLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_d;
  logic              busy_d;
  logic [1:0]        owner_d;
  logic [BCD_W-1:0]  bcd_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]  pre_q, pre_d;

  // Requests and data slices padded to four entries so a 2-bit index is always in range
  logic [3:0]        req4;
  logic [BCD_W-1:0]  slice [4];

  assign req4 = 4'(req);

  for (genvar i = 0; i < 4; i++) begin : g_slice
    if (i < NREQ) begin : g_used
      assign slice[i] = data[16*i +: 16];
    end else begin : g_pad
      assign slice[i] = BLANK;
    end
  end

  function automatic logic [BCD_W-1:0] format_bcd(input logic [BCD_W-1:0] v);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [BCD_W-1:0] r;
    logic             leading;
    r       = v;
    leading = 1'b1;
    for (int d = 3; d >= 1; d--) begin
      if (leading && (v[4*d +: 4] == 4'h0)) r[4*d +: 4] = 4'hF;
      else leading = 1'b0;
    end
    return r;
`else
    return v;
`endif
  endfunction

  // Round-robin winner: first requester after the current owner
  logic       found;
  logic [1:0] win;

  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = 2'd0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = 32'(owner) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req4[2'(idx)]) begin
        found = 1'b1;
        win   = 2'(idx);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    grant_d = '0;
    busy_d  = busy;
    owner_d = owner;
    bcd_d   = bcd_out;
    hold_d  = hold_q;
    if (clear) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      bcd_d   = BLANK;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_d = 1'b0;
          if (found) begin
            grant_d = NREQ'(1) << win;
            bcd_d   = format_bcd(slice[win]);
            owner_d = win;
            hold_d  = CNT_W'(HOLD_CYCLES - 1);
            busy_d  = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          busy_d = 1'b1;
          if (hold_q == '0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            hold_d = hold_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      owner   <= 2'(NREQ - 1);
      bcd_out <= BLANK;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      busy    <= busy_d;
      owner   <= owner_d;
      bcd_out <= bcd_d;
      hold_q  <= hold_d;
    end
  end

  // Scan prescaler; tick is registered so it is high while the count sits at SCAN_DIV-1
  assign pre_d = (pre_q == CNT_W'(SCAN_DIV - 1)) ? '0 : pre_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q     <= '0;
      scan_tick <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      scan_tick <= (pre_d == CNT_W'(SCAN_DIV - 1));
    end
  end

endmodule

// File: tb/tb_seg7_display_scheduler.sv
// Directed self-checking bench for seg7_display_scheduler (NREQ=3, HOLD_CYCLES=4, SCAN_DIV=16).
module tb_seg7_display_scheduler;

  localparam int unsigned NREQ = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic [NREQ-1:0]   req;
  logic [16*NREQ-1:0] data;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [1:0]        owner;
  logic [15:0]       bcd_out;
  logic              scan_tick;

  int total = 0;
  int bad   = 0;

  seg7_display_scheduler #(
    .NREQ(NREQ), .HOLD_CYCLES(4), .SCAN_DIV(16), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .req(req), .data(data),
    .grant(grant), .busy(busy), .owner(owner), .bcd_out(bcd_out), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  // Leaves the bench 1 time unit after a rising edge, inputs idle, reset released
  task automatic do_reset();
    req   = '0;
    clear = 1'b0;
    data  = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic edge_step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    req = '0; clear = 1'b0; data = '0;
    reset = 1'b1;
    #2;
    total++;
    if (grant !== 3'b000 || busy !== 1'b0 || owner !== 2'd2 ||
        bcd_out !== 16'hFFFF || scan_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got grant=%b busy=%b owner=%0d bcd=%h tick=%b, want 000 0 2 ffff 0",
               grant, busy, owner, bcd_out, scan_tick);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int e = 1; e <= 34; e++) begin
      edge_step();
      total++;
      if (scan_tick !== ((e % 16) == 15) || grant !== 3'b000 || busy !== 1'b0 ||
          bcd_out !== 16'hFFFF) begin
        bad++;
        $display("FAIL idle_scan e=%0d: got tick=%b grant=%b busy=%b bcd=%h, want tick=%b 000 0 ffff",
                 e, scan_tick, grant, busy, bcd_out, ((e % 16) == 15));
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_grant;
    logic [15:0] exp_bcd;
    logic        exp_busy;
    do_reset();
    req  = 3'b111;
    data = {16'h0003, 16'h0002, 16'h0001};
    exp_bcd = 16'hFFFF;
    for (int e = 1; e <= 18; e++) begin
      edge_step();
      exp_grant = 3'b000;
      case (e)
        1, 16: begin exp_grant = 3'b001; exp_bcd = 16'h0001; end
        6:     begin exp_grant = 3'b010; exp_bcd = 16'h0002; end
        11:    begin exp_grant = 3'b100; exp_bcd = 16'h0003; end
        default: ;
      endcase
      exp_busy = (e % 5) != 0;
      total++;
      if (grant !== exp_grant || bcd_out !== exp_bcd || busy !== exp_busy) begin
        bad++;
        $display("FAIL round_robin e=%0d: got grant=%b bcd=%h busy=%b, want %b %h %b",
                 e, grant, bcd_out, busy, exp_grant, exp_bcd, exp_busy);
      end
    end
  endtask

  task automatic test_sole_requester();
    do_reset();
    req  = 3'b001;
    data = {16'h0000, 16'h0000, 16'h0005};
    edge_step();
    total++;
    if (grant !== 3'b001 || bcd_out !== 16'h0005 || owner !== 2'd0) begin
      bad++;
      $display("FAIL sole_first_grant: got grant=%b bcd=%h owner=%0d, want 001 0005 0",
               grant, bcd_out, owner);
    end
    edge_step();
    data[15:0] = 16'h0006;
    for (int e = 3; e <= 5; e++) begin
      edge_step();
      total++;
      if (bcd_out !== 16'h0005 || grant !== 3'b000) begin
        bad++;
        $display("FAIL sole_hold e=%0d: got bcd=%h grant=%b, want 0005 000", e, bcd_out, grant);
      end
    end
    edge_step();
    total++;
    if (grant !== 3'b001 || bcd_out !== 16'h0006 || busy !== 1'b1) begin
      bad++;
      $display("FAIL sole_regrant: got grant=%b bcd=%h busy=%b, want 001 0006 1",
               grant, bcd_out, busy);
    end
  endtask

  task automatic test_clear();
    do_reset();
    req  = 3'b111;
    data = {16'h0003, 16'h0002, 16'h0001};
    edge_step();
    edge_step();
    clear = 1'b1;
    edge_step();
    clear = 1'b0;
    total++;
    if (bcd_out !== 16'hFFFF || busy !== 1'b0 || grant !== 3'b000 || owner !== 2'd0) begin
      bad++;
      $display("FAIL clear_abort: got bcd=%h busy=%b grant=%b owner=%0d, want ffff 0 000 0",
               bcd_out, busy, grant, owner);
    end
    edge_step();
    total++;
    if (grant !== 3'b010 || bcd_out !== 16'h0002 || owner !== 2'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL clear_next_rr: got grant=%b bcd=%h owner=%0d busy=%b, want 010 0002 1 1",
               grant, bcd_out, owner, busy);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    req  = 3'b111;
    data = {16'h0003, 16'h0002, 16'h0001};
    edge_step();
    edge_step();
    edge_step();
    req  = 3'b011;
    reset = 1'b1;
    #1;
    total++;
    if (grant !== 3'b000 || busy !== 1'b0 || owner !== 2'd2 ||
        bcd_out !== 16'hFFFF || scan_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_hold: got grant=%b busy=%b owner=%0d bcd=%h tick=%b, want 000 0 2 ffff 0",
               grant, busy, owner, bcd_out, scan_tick);
    end
    #1;
    reset = 1'b0;
    edge_step();
    total++;
    if (grant !== 3'b001 || bcd_out !== 16'h0001 || owner !== 2'd0) begin
      bad++;
      $display("FAIL reset_regrant: got grant=%b bcd=%h owner=%0d, want 001 0001 0",
               grant, bcd_out, owner);
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] exp [3];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    exp[0] = 16'hFF42; exp[1] = 16'hFFF0; exp[2] = 16'hA00B;
`else
    exp[0] = 16'h0042; exp[1] = 16'h0000; exp[2] = 16'hA00B;
`endif
    do_reset();
    req  = 3'b001;
    data = {16'h0000, 16'h0000, 16'h0042};
    edge_step();
    for (int g = 0; g < 3; g++) begin
      total++;
      if (grant !== 3'b001 || bcd_out !== exp[g]) begin
        bad++;
        $display("FAIL leading_zero g=%0d: got grant=%b bcd=%h, want 001 %h", g, grant, bcd_out, exp[g]);
      end
      data[15:0] = (g == 0) ? 16'h0000 : 16'hA00B;
      for (int c = 0; c < 5; c++) edge_step();
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; req = '0; data = '0;
    test_reset();
    test_round_robin();
    test_sole_requester();
    test_clear();
    test_reset_mid_hold();
    test_leading_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
